// File: rtl/register_bank_param.sv
// Bank of NUM_REGS independent registers with per-channel function select and zero/carry flags.
// Build option: define REGBANK_SAT_EN to make increment/decrement saturate instead of wrapping.
module register_bank_param #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      LANE        = 8,
  parameter int unsigned      NUM_REGS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [WIDTH-1:0]             I,
  input  logic [NUM_REGS-1:0]          E,
  input  logic [4*NUM_REGS-1:0]        FunSel,
  output logic [WIDTH*NUM_REGS-1:0]    Q,
  output logic [NUM_REGS-1:0]          Z,
  output logic [NUM_REGS-1:0]          C
);

  localparam int unsigned H       = WIDTH / 2;
  localparam logic        RESET_Z = (RESET_VALUE == '0);

  typedef enum logic [3:0] {
    FN_DEC       = 4'h0,
    FN_INC       = 4'h1,
    FN_LOAD      = 4'h2,
    FN_CLR       = 4'h3,
    FN_LANE_LD   = 4'h4,
    FN_HALF_LD   = 4'h5,
    FN_LANE_SHIN = 4'h6,
    FN_HALF_SEXT = 4'h7,
    FN_SHL       = 4'h8,
    FN_SHR       = 4'h9,
    FN_ASR       = 4'hA,
    FN_ROL       = 4'hB,
    FN_ROR       = 4'hC,
    FN_HIGH_LD   = 4'hD,
    FN_RSV0      = 4'hE,
    FN_RSV1      = 4'hF
  } fn_e;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_ch
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             z_r, z_nxt;
    logic             c_r, c_nxt;
    logic             upd;
    fn_e              fn;

    assign fn = fn_e'(FunSel[4*k +: 4]);

    // Next-state for one channel; reserved codes and E=0 leave Q, Z and C untouched.
    always_comb begin
      q_nxt = q_r;
      c_nxt = c_r;
      upd   = 1'b0;
      if (E[k]) begin
        upd   = 1'b1;
        c_nxt = 1'b0;
        case (fn)
          FN_DEC: begin
            c_nxt = (q_r == '0);
`ifdef REGBANK_SAT_EN
            q_nxt = (q_r == '0) ? q_r : q_r - WIDTH'(1);
`else
            q_nxt = q_r - WIDTH'(1);
`endif
          end
          FN_INC: begin
            c_nxt = (q_r == '1);
`ifdef REGBANK_SAT_EN
            q_nxt = (q_r == '1) ? q_r : q_r + WIDTH'(1);
`else
            q_nxt = q_r + WIDTH'(1);
`endif
          end
          FN_LOAD:      q_nxt = I;
          FN_CLR:       q_nxt = '0;
          FN_LANE_LD:   q_nxt = WIDTH'(I[LANE-1:0]);
          FN_HALF_LD:   q_nxt = WIDTH'(I[H-1:0]);
          FN_LANE_SHIN: q_nxt = {q_r[WIDTH-LANE-1:0], I[LANE-1:0]};
          FN_HALF_SEXT: q_nxt = {{H{I[H-1]}}, I[H-1:0]};
          FN_SHL: begin
            q_nxt = {q_r[WIDTH-2:0], 1'b0};
            c_nxt = q_r[WIDTH-1];
          end
          FN_SHR: begin
            q_nxt = {1'b0, q_r[WIDTH-1:1]};
            c_nxt = q_r[0];
          end
          FN_ASR: begin
            q_nxt = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            c_nxt = q_r[0];
          end
          FN_ROL: begin
            q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            c_nxt = q_r[WIDTH-1];
          end
          FN_ROR: begin
            q_nxt = {q_r[0], q_r[WIDTH-1:1]};
            c_nxt = q_r[0];
          end
          FN_HIGH_LD:   q_nxt = {I[H-1:0], q_r[H-1:0]};
          default: begin
            upd   = 1'b0;
            c_nxt = c_r;
          end
        endcase
      end
      z_nxt = upd ? (q_nxt == '0) : z_r;
    end

    always_ff @(posedge Clock) begin
      if (!Reset) begin
        q_r <= RESET_VALUE;
        z_r <= RESET_Z;
        c_r <= 1'b0;
      end else begin
        q_r <= q_nxt;
        z_r <= z_nxt;
        c_r <= c_nxt;
      end
    end

    assign Q[WIDTH*k +: WIDTH] = q_r;
    assign Z[k]                = z_r;
    assign C[k]                = c_r;
  end

endmodule

// File: tb/tb_register_bank_param.sv
// Scoreboard bench for register_bank_param (WIDTH=16, LANE=8, NUM_REGS=4); honours REGBANK_SAT_EN.
module tb_register_bank_param;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int MODV = 65536;
  localparam int MAXV = 65535;
  localparam int LMOD = 256;
  localparam int HMOD = 256;

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic [W-1:0]   I = '0;
  logic [N-1:0]   E = '0;
  logic [4*N-1:0] FunSel = '0;
  logic [W*N-1:0] Q;
  logic [N-1:0]   Z;
  logic [N-1:0]   C;

  register_bank_param #(.WIDTH(W), .LANE(8), .NUM_REGS(N), .RESET_VALUE(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .E(E), .FunSel(FunSel), .Q(Q), .Z(Z), .C(C)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [W*N-1:0] q;
    logic [N-1:0]   z;
    logic [N-1:0]   c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   mq[N];
  bit   mz[N];
  bit   mc[N];

  // Reference model: plain integer arithmetic on each register value.
  task automatic model_step(input logic rst, input logic [N-1:0] e, input logic [4*N-1:0] fs,
                            input logic [W-1:0] iv);
    int  q, nq, i, lo;
    bit  nc, upd;
    logic [3:0] f;
    for (int k = 0; k < N; k++) begin
      if (!rst) begin
        mq[k] = 0; mz[k] = 1'b1; mc[k] = 1'b0;
      end else if (e[k]) begin
        f = fs[4*k +: 4];
        q = mq[k]; i = int'(iv); lo = i % LMOD;
        nq = q; nc = 1'b0; upd = 1'b1;
        case (f)
          4'h0: if (q == 0) begin
`ifdef REGBANK_SAT_EN
                  nq = 0;
`else
                  nq = MAXV;
`endif
                  nc = 1'b1;
                end else nq = q - 1;
          4'h1: if (q == MAXV) begin
`ifdef REGBANK_SAT_EN
                  nq = MAXV;
`else
                  nq = 0;
`endif
                  nc = 1'b1;
                end else nq = q + 1;
          4'h2: nq = i;
          4'h3: nq = 0;
          4'h4: nq = lo;
          4'h5: nq = i % HMOD;
          4'h6: nq = (q % (MODV / LMOD)) * LMOD + lo;
          4'h7: nq = (i % HMOD) + (((i % HMOD) >= HMOD / 2) ? (MODV - HMOD) : 0);
          4'h8: begin nq = (q * 2) % MODV; nc = (q >= MODV / 2); end
          4'h9: begin nq = q / 2; nc = (q % 2 == 1); end
          4'hA: begin nq = q / 2 + ((q >= MODV / 2) ? MODV / 2 : 0); nc = (q % 2 == 1); end
          4'hB: begin nq = (q * 2) % MODV + q / (MODV / 2); nc = (q >= MODV / 2); end
          4'hC: begin nq = q / 2 + (q % 2) * (MODV / 2); nc = (q % 2 == 1); end
          4'hD: nq = (i % HMOD) * HMOD + q % HMOD;
          default: upd = 1'b0;
        endcase
        if (upd) begin
          mq[k] = nq; mc[k] = nc; mz[k] = (nq == 0);
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] e, input logic [4*N-1:0] fs,
                      input logic [W-1:0] iv);
    exp_t x;
    @(negedge Clock);
    Reset = rst; E = e; FunSel = fs; I = iv;
    model_step(rst, e, fs, iv);
    for (int k = 0; k < N; k++) begin
      x.q[W*k +: W] = W'(mq[k]);
      x.z[k] = mz[k];
      x.c[k] = mc[k];
    end
    sb.push_back(x);
  endtask

  // Direct check of one channel against a hand-derived constant, right after the stepped edge.
  task automatic chk(input string name, input int ch, input logic [W-1:0] q, input logic z,
                     input logic c);
    @(posedge Clock);
    #2;
    checks++;
    if (Q[W*ch +: W] !== q || Z[ch] !== z || C[ch] !== c) begin
      failures++;
      $display("FAIL %s ch%0d: got Q=%h Z=%b C=%b want Q=%h Z=%b C=%b",
               name, ch, Q[W*ch +: W], Z[ch], C[ch], q, z, c);
    end
  endtask

  function automatic logic [4*N-1:0] fs_all(input logic [3:0] f);
    return {N{f}};
  endfunction

  // Monitor: every edge produces a result; pop and compare whenever one is expected.
  initial begin
    exp_t x;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        for (int k = 0; k < N; k++) begin
          checks++;
          if (Q[W*k +: W] !== x.q[W*k +: W] || Z[k] !== x.z[k] || C[k] !== x.c[k]) begin
            failures++;
            $display("FAIL sb ch%0d @%0t: got Q=%h Z=%b C=%b want Q=%h Z=%b C=%b", k, $time,
                     Q[W*k +: W], Z[k], C[k], x.q[W*k +: W], x.z[k], x.c[k]);
          end
        end
      end
    end
  end

  initial begin
    logic [4*N-1:0] fs;
    logic [W-1:0]   iv;
    int             waited;

    step(1'b0, 4'b0000, '0, '0);
    chk("reset", 0, 16'h0000, 1'b1, 1'b0);
    chk("reset_hold", 3, 16'h0000, 1'b1, 1'b0);
    repeat (5) step(1'b1, 4'b0000, fs_all(4'h1), W'($urandom));

    // Wrap / saturate on channel 0
    step(1'b1, 4'b0001, fs_all(4'h2), 16'hFFFF);
    step(1'b1, 4'b0001, fs_all(4'h1), 16'h0000);
`ifdef REGBANK_SAT_EN
    chk("inc_sat", 0, 16'hFFFF, 1'b0, 1'b1);
`else
    chk("inc_wrap", 0, 16'h0000, 1'b1, 1'b1);
`endif
    step(1'b1, 4'b0001, fs_all(4'h3), 16'h0000);
    step(1'b1, 4'b0001, fs_all(4'h0), 16'h0000);
`ifdef REGBANK_SAT_EN
    chk("dec_sat", 0, 16'h0000, 1'b1, 1'b1);
`else
    chk("dec_wrap", 0, 16'hFFFF, 1'b0, 1'b1);
`endif

    // Lane and half functions
    step(1'b1, 4'b0001, fs_all(4'h2), 16'h00CD);
    step(1'b1, 4'b0001, fs_all(4'h6), 16'h12AB);
    chk("lane_shin", 0, 16'hCDAB, 1'b0, 1'b0);
    step(1'b1, 4'b0001, fs_all(4'h7), 16'h0080);
    chk("half_sext", 0, 16'hFF80, 1'b0, 1'b0);
    step(1'b1, 4'b0001, fs_all(4'h2), 16'h5678);
    step(1'b1, 4'b0001, fs_all(4'hD), 16'h0034);
    chk("high_ld", 0, 16'h3478, 1'b0, 1'b0);

    // Shifts on 0x8001
    step(1'b1, 4'b0001, fs_all(4'h2), 16'h8001);
    step(1'b1, 4'b0001, fs_all(4'h8), 16'h0000);
    chk("shl", 0, 16'h0002, 1'b0, 1'b1);
    step(1'b1, 4'b0001, fs_all(4'h2), 16'h8001);
    step(1'b1, 4'b0001, fs_all(4'hA), 16'h0000);
    chk("asr", 0, 16'hC000, 1'b0, 1'b1);
    step(1'b1, 4'b0001, fs_all(4'h2), 16'h8001);
    step(1'b1, 4'b0001, fs_all(4'hC), 16'h0000);
    chk("ror", 0, 16'hC000, 1'b0, 1'b1);
    step(1'b1, 4'b0001, fs_all(4'h2), 16'h8001);
    step(1'b1, 4'b0001, fs_all(4'h9), 16'h0000);
    chk("shr", 0, 16'h4000, 1'b0, 1'b1);

    // Independence: ch3 preloaded, then held while others act on the same edge
    step(1'b1, 4'b1111, fs_all(4'h2), 16'h00F0);
    step(1'b1, 4'b0111, {4'h2, 4'h3, 4'h2, 4'h1}, 16'h1234);
    chk("indep_inc", 0, 16'h00F1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, fs_all(4'hE), 16'h0000);
    chk("indep_load", 1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 4'b0000, fs_all(4'hE), 16'h0000);
    chk("indep_clr", 2, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, fs_all(4'hE), 16'h0000);
    chk("indep_hold", 3, 16'h00F0, 1'b0, 1'b0);

    // Reset wins over enable and load
    step(1'b0, 4'b1111, fs_all(4'h2), 16'hBEEF);
    chk("rst_prio", 1, 16'h0000, 1'b1, 1'b0);

    // Randomised traffic with boundary-biased data
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) fs[4*k +: 4] = 4'($urandom_range(0, 1));
        else fs[4*k +: 4] = 4'($urandom_range(0, 15));
      end
      case ($urandom_range(0, 5))
        0: iv = 16'h0000;
        1: iv = 16'hFFFF;
        2: iv = 16'h8001;
        default: iv = W'($urandom);
      endcase
      step(($urandom_range(0, 40) != 0), N'($urandom), fs, iv);
    end
    step(1'b1, 4'b0000, '0, '0);

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(posedge Clock);
      waited++;
    end
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_param.md
# register_bank_param

Parametrised bank of NUM_REGS independent general-purpose registers, each WIDTH bits wide, sharing one data input and one clock. It is the next-generation register primitive for the datapath. Each channel has its own enable and 4-bit function select. The function set adds shifts, rotates, half-word loads and per-channel zero/carry status flags. Status flags feed the ALU/flag logic and the control unit.

## Interface
- WIDTH, default 32: data width of each register; must be even and at least 2*LANE.
- LANE, default 8: width of the byte lane used by lane-load and lane-shift functions.
- NUM_REGS, default 4: number of register channels, minimum 1.
- RESET_VALUE, default 0: value loaded into every register on reset.
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- I  input  WIDTH  shared data input for all channels.
- E  input  NUM_REGS  per-channel enable; bit k gates channel k.
- FunSel  input  4*NUM_REGS  per-channel function select; channel k uses FunSel[4k+3:4k].
- Q  output  WIDTH*NUM_REGS  register contents; channel k on Q[WIDTH*k+WIDTH-1:WIDTH*k].
- Z  output  NUM_REGS  registered zero flag per channel.
- C  output  NUM_REGS  registered carry/shift-out flag per channel.

## Operation
- Reset has priority over E and FunSel. On reset:
  - every Q = RESET_VALUE.
  - Z = (RESET_VALUE == 0).
  - C = 0.
- E[k]=0: channel k holds Q, Z and C unchanged, regardless of its FunSel.
- E[k]=1: channel k applies its FunSel (H = WIDTH/2):
  - 0000 decrement: Q-1. C=1 on borrow (Q was 0).
  - 0001 increment: Q+1. C=1 on carry-out (Q was all-ones).
  - 0010 load: Q=I. C=0.
  - 0011 clear: Q=0. C=0.
  - 0100 lane load: Q = zero-extended I[LANE-1:0]. C=0.
  - 0101 half load: Q = zero-extended I[H-1:0]. C=0.
  - 0110 lane shift-in: Q = {Q[WIDTH-LANE-1:0], I[LANE-1:0]}. C=0.
  - 0111 half sign-extend: Q = sign-extended I[H-1:0]. C=0.
  - 1000 logical shift left 1: C = old Q[WIDTH-1].
  - 1001 logical shift right 1: C = old Q[0].
  - 1010 arithmetic shift right 1: MSB replicated; C = old Q[0].
  - 1011 rotate left 1: C = old Q[WIDTH-1].
  - 1100 rotate right 1: C = old Q[0].
  - 1101 high-half load: Q[WIDTH-1:H] = I[H-1:0]; low half kept. C=0.
  - 1110, 1111 reserved: hold Q, Z and C.
- Z updates whenever Q updates and equals (new Q == 0). It is never combinational from Q.
- Channels are fully independent. Any mix of enables and functions in the same cycle is legal. All channels may read I simultaneously.

## Timing
- Latency is one cycle. Controls sampled at edge n appear on Q/Z/C after edge n.
- Q, Z and C are registered outputs, with no combinational path from inputs to outputs.
- Reset asserted mid-sequence (e.g. during repeated increments) wins at that edge. Counting resumes from RESET_VALUE on the first edge with Reset=1.
- Wrap-around without saturation: increment at all-ones gives 0, Z=1, C=1; decrement at 0 gives all-ones, Z=0, C=1.

## Configuration
- Macro REGBANK_SAT_EN.
- Defined: increment/decrement saturate.
  - Increment at all-ones keeps all-ones with C=1.
  - Decrement at 0 keeps 0 with C=1 and Z=1.
- Undefined: modular wrap as specified under Timing.
- All other functions are identical in both builds.

## Test plan
Configuration for all scenarios: WIDTH=16, LANE=8, NUM_REGS=4, RESET_VALUE=0.
- Reset/hold:
  - Reset=0 for 1 edge → all Q=0x0000, Z=4'b1111, C=0.
  - Then E=0 with FunSel=0001 for 5 edges → outputs unchanged.
- Wrap (macro off): channel 0 load 0xFFFF, then increment → Q0=0x0000, Z0=1, C0=1. Decrement again → Q0=0xFFFF, C0=1.
- Saturation (REGBANK_SAT_EN): channel 0 at 0xFFFF, increment → 0xFFFF, C0=1. Clear then decrement → 0x0000, Z0=1, C0=1.
- Lane/half functions, I=0x12AB:
  - lane shift-in after load 0x00CD → 0xCDAB.
  - half sign-extend with I=0x0080 → 0xFF80.
  - high-half load with I=0x0034 on 0x5678 → 0x3478.
- Shifts on Q=0x8001:
  - shift left → 0x0002, C=1.
  - arithmetic shift right → 0xC000, C=1.
  - rotate right → 0xC000, C=1.
  - logical shift right → 0x4000, C=1.
- Independence/reset priority:
  - Same edge: ch0 increment, ch1 load I=0x1234, ch2 clear, ch3 E=0 → each channel matches its rule.
  - Reset=0 asserted together with E=1111, FunSel=load → all Q=0x0000.
